// File: rtl/btle_rx_pkg.sv
// Shared definitions for the BLE receiver PDU drain stage: state encoding,
// PDU memory geometry and the frame-length clamp.
package btle_rx_pkg;

    localparam int PDU_ADDR_W        = 6;
    localparam int MAX_FRAME_OCTETS  = 64;
    localparam int DEF_HEADER_OCTETS = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

    // Frame length in octets: payload plus header, summed 8 bits wide and
    // clamped to the size of the PDU octet memory.
    function automatic logic [6:0] frame_octets(input logic [6:0] payload_len,
                                                input logic [7:0] header);
        logic [7:0] sum;
        sum = {1'b0, payload_len} + header;
        return (sum > 8'(MAX_FRAME_OCTETS)) ? 7'(MAX_FRAME_OCTETS) : sum[6:0];
    endfunction

endpackage

// File: rtl/btle_rx_pdu_fetch_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/btle_rx_pdu_fetch.sv
// Drains the winning phase's PDU octet memory after decode end and emits the
// frame as a valid/ready byte stream with last flag, status and statistics.
module btle_rx_pdu_fetch
    import btle_rx_pkg::*;
#(
    parameter int READ_LATENCY  = 1,
    parameter int DROP_CRC_FAIL = 1,
    parameter int HEADER_OCTETS = DEF_HEADER_OCTETS,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_hit_flag,
    input  logic                  rx_decode_end,
    input  logic                  rx_crc_ok,
    input  logic [2:0]            rx_best_phase,
    input  logic [6:0]            rx_payload_length,
    output logic [PDU_ADDR_W-1:0] pdu_octet_mem_addr,
    input  logic [7:0]            pdu_octet_mem_data,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  frame_crc_ok,
    output logic [2:0]            frame_phase,
    output logic [6:0]            frame_len,
    output logic                  frame_abort,
    output logic                  busy,
    output logic [COUNT_WIDTH-1:0] cnt_ok,
    output logic [COUNT_WIDTH-1:0] cnt_drop,
    output logic [COUNT_WIDTH-1:0] cnt_overrun
);

    // WAIT spans READ_LATENCY+1 cycles: address settle plus memory latency.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY);

    fetch_state_e          state, state_d;
    logic [1:0]            wait_cnt, wait_d;
    logic [6:0]            n_oct, n_d;
    logic                  abort_pend, pend_d;
    logic [PDU_ADDR_W-1:0] addr_d;
    logic [7:0]            data_d;
    logic                  valid_d, last_d, crc_d, abort_d;
    logic [2:0]            phase_d;
    logic [6:0]            len_d;
    logic                  inc_ok, inc_drop, inc_ovr;

    // Next-state and next-output decode for the fetch sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d  = state;
        wait_d   = wait_cnt;
        n_d      = n_oct;
        pend_d   = abort_pend;
        addr_d   = pdu_octet_mem_addr;
        data_d   = m_data;
        valid_d  = m_valid;
        last_d   = m_last;
        crc_d    = frame_crc_ok;
        phase_d  = frame_phase;
        len_d    = frame_len;
        abort_d  = 1'b0;
        inc_ok   = 1'b0;
        inc_drop = 1'b0;
        inc_ovr  = 1'b0;

        unique case (state)
            S_IDLE: begin
                // decode_end takes priority over a coincident hit here
                if (rx_decode_end) begin
                    crc_d   = rx_crc_ok;
                    phase_d = rx_best_phase;
                    len_d   = rx_payload_length;
                    if (!rx_crc_ok && (DROP_CRC_FAIL != 0)) begin
                        inc_drop = 1'b1;
                    end else begin
                        inc_ok  = rx_crc_ok;
                        addr_d  = '0;
                        wait_d  = '0;
                        pend_d  = 1'b0;
                        n_d     = frame_octets(rx_payload_length, 8'(HEADER_OCTETS));
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                inc_ovr = rx_decode_end;
                if (rx_hit_flag) begin
                    // memory is about to be overwritten: nothing in flight to finish
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    data_d  = pdu_octet_mem_data;
                    last_d  = ({1'b0, pdu_octet_mem_addr} + 7'd1) >= n_oct;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end else begin
                    wait_d = wait_cnt + 2'd1;
                end
            end

            S_OUT: begin
                inc_ovr = rx_decode_end;
                // a hit during a stalled beat is remembered until the handshake
                pend_d  = abort_pend | rx_hit_flag;
                if (m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (m_last) begin
                        state_d = S_IDLE;
                    end else if (abort_pend || rx_hit_flag) begin
                        abort_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = pdu_octet_mem_addr + PDU_ADDR_W'(1);
                        wait_d  = '0;
                        state_d = S_WAIT;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Register state and every output; reset returns to IDLE without an abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            wait_cnt           <= '0;
            n_oct              <= '0;
            abort_pend         <= 1'b0;
            pdu_octet_mem_addr <= '0;
            m_data             <= '0;
            m_valid            <= 1'b0;
            m_last             <= 1'b0;
            frame_crc_ok       <= 1'b0;
            frame_phase        <= '0;
            frame_len          <= '0;
            frame_abort        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state              <= state_d;
            wait_cnt           <= wait_d;
            n_oct              <= n_d;
            abort_pend         <= pend_d;
            pdu_octet_mem_addr <= addr_d;
            m_data             <= data_d;
            m_valid            <= valid_d;
            m_last             <= last_d;
            frame_crc_ok       <= crc_d;
            frame_phase        <= phase_d;
            frame_len          <= len_d;
            frame_abort        <= abort_d;
            busy               <= (state_d != S_IDLE);
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_ok (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (inc_ok),
        .count (cnt_ok)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_drop (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (inc_drop),
        .count (cnt_drop)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_overrun (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (inc_ovr),
        .count (cnt_overrun)
    );

endmodule

// File: tb/tb_btle_rx_pdu_fetch.sv
// Self-checking bench for btle_rx_pdu_fetch: table of frames, hand-written
// abort/overrun/saturation/reset sequences, then randomized frames.
module tb_btle_rx_pdu_fetch;

    localparam int RL   = 1;
    localparam int HDR  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_hit_flag, rx_decode_end, rx_crc_ok;
    logic [2:0]  rx_best_phase;
    logic [6:0]  rx_payload_length;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  m_data;
    logic        m_valid, m_ready, m_last;
    logic        frame_crc_ok, frame_abort, busy;
    logic [2:0]  frame_phase;
    logic [6:0]  frame_len;
    logic [CW-1:0] cnt_ok, cnt_drop, cnt_overrun;

    always #5 clk = ~clk;

    btle_rx_pdu_fetch #(
        .READ_LATENCY (RL),
        .DROP_CRC_FAIL(1),
        .HEADER_OCTETS(HDR),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_hit_flag       (rx_hit_flag),
        .rx_decode_end     (rx_decode_end),
        .rx_crc_ok         (rx_crc_ok),
        .rx_best_phase     (rx_best_phase),
        .rx_payload_length (rx_payload_length),
        .pdu_octet_mem_addr(mem_addr),
        .pdu_octet_mem_data(mem_data),
        .m_data            (m_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_last            (m_last),
        .frame_crc_ok      (frame_crc_ok),
        .frame_phase       (frame_phase),
        .frame_len         (frame_len),
        .frame_abort       (frame_abort),
        .busy              (busy),
        .cnt_ok            (cnt_ok),
        .cnt_drop          (cnt_drop),
        .cnt_overrun       (cnt_overrun)
    );

    // Receiver octet memory with an RL-stage registered read path
    logic [7:0] mem  [64];
    logic [7:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data = pipe[RL-1];

    // Scoreboard
    int n_pass = 0, n_total = 0;
    int m_ok = 0, m_drop = 0, m_ovr = 0;

    logic [7:0] got_q[$];
    logic       got_last_q[$];
    int first_lat, last_hs, stab_err, max_addr, addr0;
    bit done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Frame length from the rules: payload plus header, capped at the memory size
    function automatic int model_n(input int len);
        return (len + HDR > 64) ? 64 : len + HDR;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, ".cnt_ok"},      32'(cnt_ok),      32'(sat(m_ok)));
        check({tag, ".cnt_drop"},    32'(cnt_drop),    32'(sat(m_drop)));
        check({tag, ".cnt_overrun"}, 32'(cnt_overrun), 32'(sat(m_ovr)));
    endtask

    // Pulse decode_end for one cycle; returns at the negedge of the following cycle
    task automatic start_frame(input logic [6:0] len, input logic crc, input logic [2:0] ph);
        @(negedge clk);
        rx_decode_end     = 1'b1;
        rx_crc_ok         = crc;
        rx_best_phase     = ph;
        rx_payload_length = len;
        @(negedge clk);
        rx_decode_end = 1'b0;
    endtask

    // Drain one streamed frame. ready_mode: 0 always, 1 one cycle in four, 2 random.
    // ovr_mode: 0 none, 1 random busy decode_end pulses, 2 pulses at fixed cycles.
    task automatic collect(input int ready_mode, input int ovr_mode);
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        got_q.delete();
        got_last_q.delete();
        first_lat = -1; last_hs = -1; stab_err = 0; max_addr = 0; done = 1'b0;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        addr0 = int'(mem_addr);
        for (int k = 0; k < BUDGET && !done; k++) begin
            if (prev_stall && !(m_valid && m_data == prev_d && m_last == prev_l)) stab_err++;
            if (m_valid && first_lat < 0) first_lat = k + 1;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 4 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (ovr_mode)
                1:       rx_decode_end = ($urandom_range(0, 15) == 0);
                2:       rx_decode_end = (k == 0 || k == 2);
                default: rx_decode_end = 1'b0;
            endcase
            if (rx_decode_end) m_ovr++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
                last_hs = k + 1;
                if (m_last) done = 1'b1;
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_valid;
                prev_d     = m_data;
                prev_l     = m_last;
            end
            @(negedge clk);
        end
        rx_decode_end = 1'b0;
        m_ready       = 1'b0;
    endtask

    task automatic verify_stream(input string tag, input int exp_n, input int ready_mode);
        int mism, lerr;
        mism = 0; lerr = 0;
        check({tag, ".done"},  32'(done), 32'd1);
        check({tag, ".beats"}, 32'(got_q.size()), 32'(exp_n));
        foreach (got_q[i]) begin
            if (i < 64 && got_q[i] !== mem[i]) mism++;
            if (got_last_q[i] !== (i == got_q.size() - 1)) lerr++;
        end
        check({tag, ".data"}, 32'(mism), 32'd0);
        check({tag, ".last"}, 32'(lerr), 32'd0);
        check({tag, ".latency"}, 32'(first_lat), 32'(RL + 2));
        check({tag, ".addr0"}, 32'(addr0), 32'd0);
        check({tag, ".max_addr"}, 32'(max_addr), 32'(exp_n - 1));
        if (ready_mode == 0) check({tag, ".throughput"}, 32'(last_hs), 32'(exp_n * (RL + 2)));
        else                 check({tag, ".stable"}, 32'(stab_err), 32'd0);
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
    endtask

    // Dropped frame: nothing may be presented and the block never goes busy
    task automatic watch_drop(input string tag);
        int err;
        err = 0;
        for (int k = 0; k < 5; k++) begin
            if (m_valid || busy) err++;
            @(negedge clk);
        end
        check({tag, ".no_stream"}, 32'(err), 32'd0);
    endtask

    typedef struct {
        logic [6:0] len;
        logic       crc;
        logic [2:0] phase;
        int         ready_mode;
        int         exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{7'd5,  1'b1, 3'd3, 0, 7};
        vecs[1] = '{7'd0,  1'b0, 3'd1, 0, 0};
        vecs[2] = '{7'd70, 1'b1, 3'd7, 0, 64};
        vecs[3] = '{7'd2,  1'b1, 3'd5, 1, 4};
        vecs[4] = '{7'd3,  1'b0, 3'd2, 0, 0};
        vecs[5] = '{7'd62, 1'b1, 3'd6, 2, 64};
        vecs[6] = '{7'd61, 1'b1, 3'd4, 1, 63};

        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        rst_n = 1'b0; rx_hit_flag = 1'b0; rx_decode_end = 1'b0; rx_crc_ok = 1'b0;
        rx_best_phase = '0; rx_payload_length = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.m_valid", 32'(m_valid), 32'd0);
        check("rst.m_last",  32'(m_last), 32'd0);
        check("rst.m_data",  32'(m_data), 32'd0);
        check("rst.busy",    32'(busy), 32'd0);
        check("rst.addr",    32'(mem_addr), 32'd0);
        check("rst.frame",   32'({frame_crc_ok, frame_phase, frame_len, frame_abort}), 32'd0);
        check_counters("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_frame(vecs[i].len, vecs[i].crc, vecs[i].phase);
            check({tag, ".frame_phase"}, 32'(frame_phase), 32'(vecs[i].phase));
            check({tag, ".frame_len"},   32'(frame_len), 32'(vecs[i].len));
            check({tag, ".frame_crc"},   32'(frame_crc_ok), 32'(vecs[i].crc));
            if (vecs[i].crc) begin
                m_ok++;
                collect(vecs[i].ready_mode, 0);
                verify_stream(tag, vecs[i].exp_beats, vecs[i].ready_mode);
                check({tag, ".phase_held"}, 32'(frame_phase), 32'(vecs[i].phase));
            end else begin
                m_drop++;
                watch_drop(tag);
            end
            check_counters(tag);
        end

        // decode_end while busy: counted as overrun, frame continues untouched
        start_frame(7'd3, 1'b1, 3'd2);
        m_ok++;
        collect(0, 2);
        verify_stream("ovr", 5, 0);
        check("ovr.frame_len", 32'(frame_len), 32'd3);
        check_counters("ovr");

        // Hit during WAIT of beat index 2: two beats out, abort pulse, IDLE
        begin
            int hs, lasts;
            bit hit_sent;
            hs = 0; lasts = 0; hit_sent = 1'b0;
            start_frame(7'd4, 1'b1, 3'd1);
            m_ok++;
            m_ready = 1'b1;
            for (int k = 0; k < 50 && !hit_sent; k++) begin
                if (m_valid) begin
                    hs++;
                    if (m_last) lasts++;
                    @(negedge clk);
                end else if (hs == 2) begin
                    rx_hit_flag = 1'b1;
                    hit_sent = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            check("hitwait.sent", 32'(hit_sent), 32'd1);
            @(negedge clk);
            rx_hit_flag = 1'b0;
            check("hitwait.abort", 32'(frame_abort), 32'd1);
            check("hitwait.busy",  32'(busy), 32'd0);
            check("hitwait.valid", 32'(m_valid), 32'd0);
            check("hitwait.beats", 32'(hs), 32'd2);
            check("hitwait.lasts", 32'(lasts), 32'd0);
            @(negedge clk);
            check("hitwait.abort_pulse", 32'(frame_abort), 32'd0);
            check("hitwait.still_idle", 32'({m_valid, busy}), 32'd0);
            m_ready = 1'b0;
        end

        // Hit while OUT is stalled: beat completes, then abort
        begin
            int k;
            start_frame(7'd4, 1'b1, 3'd6);
            m_ok++;
            k = 0;
            while (!m_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("hitout.valid_seen", 32'(m_valid), 32'd1);
            rx_hit_flag = 1'b1;
            @(negedge clk);
            rx_hit_flag = 1'b0;
            check("hitout.held_valid", 32'(m_valid), 32'd1);
            check("hitout.no_early_abort", 32'(frame_abort), 32'd0);
            @(negedge clk);
            check("hitout.held_data", 32'(m_data), 32'(mem[0]));
            check("hitout.busy", 32'(busy), 32'd1);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            check("hitout.abort", 32'(frame_abort), 32'd1);
            check("hitout.idle", 32'({m_valid, busy}), 32'd0);
            @(negedge clk);
            check("hitout.abort_pulse", 32'(frame_abort), 32'd0);
        end
        check_counters("hits");

        // Drive cnt_drop past all-ones
        for (int i = 0; i < CMAX + 4; i++) begin
            start_frame(7'(i), 1'b0, 3'd0);
            m_drop++;
        end
        @(negedge clk);
        check("sat.cnt_drop_max", 32'(cnt_drop), 32'(CMAX));
        check_counters("sat");

        // Reset in the middle of a frame
        start_frame(7'd10, 1'b1, 3'd5);
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b0;
        m_ok = 0; m_drop = 0; m_ovr = 0;
        check("midrst.valid", 32'(m_valid), 32'd0);
        check("midrst.busy",  32'(busy), 32'd0);
        check("midrst.abort", 32'(frame_abort), 32'd0);
        check("midrst.frame", 32'({frame_crc_ok, frame_phase, frame_len}), 32'd0);
        check_counters("midrst");
        @(negedge clk);
        check("midrst.quiet", 32'({m_valid, busy, frame_abort}), 32'd0);

        // Randomized frames against the reference model
        for (int r = 0; r < 25; r++) begin
            int len;
            logic crc;
            logic [2:0] ph;
            string tag;
            tag = $sformatf("rnd%0d", r);
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            len = $urandom_range(0, 90);
            crc = ($urandom_range(0, 3) != 0);
            ph  = 3'($urandom);
            start_frame(7'(len), crc, ph);
            check({tag, ".frame_len"}, 32'(frame_len), 32'(len));
            if (crc) begin
                m_ok++;
                collect(2, 1);
                verify_stream(tag, model_n(len), 2);
                check({tag, ".frame_phase"}, 32'(frame_phase), 32'(ph));
            end else begin
                m_drop++;
                watch_drop(tag);
            end
            check_counters(tag);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
